// File: rtl/perf_counter_bank.sv
// perf_counter_bank: machine-mode counter bank (cycle, time, instret and
// NUM_EVENTS hpm counters) with per-counter inhibit, a time prescaler and a
// CSR port whose read data and error flag are registered (1-cycle latency).
// Optional feature macro: PERF_OVERFLOW_IRQ_EN adds sticky per-counter
// overflow flags at CSR 0x3A0 (write-1-to-clear) and the overflow_irq_o output.
module perf_counter_bank #(
    parameter int NUM_EVENTS    = 4,
    parameter int COUNTER_WIDTH = 64,
    parameter int TIME_DIV      = 1
) (
    input  logic                                         clk_i,
    input  logic                                         reset_i,
    input  logic                                         pipe_enable_i,
    input  logic                                         retire_i,
    input  logic [((NUM_EVENTS > 0) ? NUM_EVENTS : 1)-1:0] event_in_i,
    input  logic [11:0]                                  csr_address_i,
    input  logic                                         csr_read_enable_i,
    input  logic                                         csr_write_enable_i,
    input  logic [31:0]                                  csr_write_data_i,
`ifdef PERF_OVERFLOW_IRQ_EN
    output logic                                         overflow_irq_o,
`endif
    output logic [31:0]                                  csr_read_data_o,
    output logic                                         csr_read_valid_o,
    output logic                                         csr_illegal_o
);

    localparam int          CW       = COUNTER_WIDTH;
    // Counter k sits at CSR index k and at bit k of mcountinhibit/overflow.
    // Index 1 is time: readable, never writable, never inhibited.
    localparam int          NC       = 3 + NUM_EVENTS;
    localparam logic [5:0]  NC6      = 6'(NC);
    localparam logic [31:0] PRE_TC   = 32'(TIME_DIV - 1);
    localparam logic [31:0] CTR_MASK = 32'h5 | 32'(((64'd1 << NUM_EVENTS) - 64'd1) << 3);

    logic [31:0]          inhibit_q, inhibit_d;
    logic [31:0]          pre_q, pre_d;
    logic                 time_tc;
    logic [4:0]           idx;
    logic                 c_lo, c_hi, b_lo, b_hi, idx_ok, b_ok;
    logic                 wr_sel_lo, wr_sel_hi;
    logic [NC:0][CW-1:0]  rd_chain;
    logic [63:0]          sel64;
    logic [31:0]          rd_word;
    logic                 rd_map, wr_map;
    logic [31:0]          rd_data_q;
    logic                 rd_valid_q, illegal_q;
`ifdef PERF_OVERFLOW_IRQ_EN
    logic [NC-1:0]        wrap_vec;
    logic [31:0]          ovf_q, ovf_d, ovf_clr;
    logic                 irq_q;
`endif

    assign idx       = csr_address_i[4:0];
    assign c_lo      = (csr_address_i[11:5] == 7'h60);   // C00..C1F
    assign c_hi      = (csr_address_i[11:5] == 7'h64);   // C80..C9F
    assign b_lo      = (csr_address_i[11:5] == 7'h58);   // B00..B1F
    assign b_hi      = (csr_address_i[11:5] == 7'h5C);   // B80..B9F
    assign idx_ok    = ({1'b0, idx} < NC6);
    assign b_ok      = idx_ok && (idx != 5'd1);
    assign wr_sel_lo = csr_write_enable_i && b_lo && b_ok;
    assign wr_sel_hi = csr_write_enable_i && b_hi && b_ok;

    assign time_tc   = (pre_q == PRE_TC);
    assign pre_d     = time_tc ? '0 : pre_q + 32'd1;
    assign inhibit_d = (csr_write_enable_i && (csr_address_i == 12'h320))
                       ? (csr_write_data_i & CTR_MASK) : inhibit_q;

    assign rd_chain[0] = '0;
    assign sel64       = 64'(rd_chain[NC]);

    for (genvar k = 0; k < NC; k++) begin : g_cnt
        logic [CW-1:0] val_q;
        logic          inc, wr_lo, wr_hi;

        if (k == 0) begin : g_cy
            assign inc = ~inhibit_q[0];
        end else if (k == 1) begin : g_tm
            assign inc = time_tc;
        end else if (k == 2) begin : g_ir
            assign inc = retire_i & pipe_enable_i & ~inhibit_q[2];
        end else begin : g_hpm
            assign inc = event_in_i[k-3] & ~inhibit_q[k];
        end

        assign wr_lo = wr_sel_lo && (idx == 5'(k));
        assign wr_hi = wr_sel_hi && (idx == 5'(k));
        assign rd_chain[k+1] = rd_chain[k] | ((idx == 5'(k)) ? val_q : '0);
`ifdef PERF_OVERFLOW_IRQ_EN
        assign wrap_vec[k] = inc && !wr_lo && !wr_hi && (&val_q);
`endif

        // Counter update: a write to either half wins over the increment.
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                val_q <= '0;
            end else if (wr_lo) begin
                val_q <= {val_q[CW-1:32], csr_write_data_i};
            end else if (wr_hi) begin
                val_q <= {csr_write_data_i[CW-33:0], val_q[31:0]};
            end else if (inc) begin
                val_q <= val_q + 1'b1;
            end
        end
    end

    // Read-side address decode and data select.
    always_comb begin
        rd_word = '0;
        rd_map  = 1'b0;
        if (((c_lo || c_hi) && idx_ok) || ((b_lo || b_hi) && b_ok)) begin
            rd_map  = 1'b1;
            rd_word = (c_hi || b_hi) ? sel64[63:32] : sel64[31:0];
        end else if (csr_address_i == 12'h320) begin
            rd_map  = 1'b1;
            rd_word = inhibit_q;
        end
`ifdef PERF_OVERFLOW_IRQ_EN
        else if (csr_address_i == 12'h3A0) begin
            rd_map  = 1'b1;
            rd_word = ovf_q;
        end
`endif
    end

    // Write-side legality: only B-range counters and the control CSRs.
    always_comb begin
        wr_map = ((b_lo || b_hi) && b_ok) || (csr_address_i == 12'h320);
`ifdef PERF_OVERFLOW_IRQ_EN
        if (csr_address_i == 12'h3A0) begin
            wr_map = 1'b1;
        end
`endif
    end

    // CSR response registers, inhibit mask and time prescaler.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            inhibit_q  <= '0;
            pre_q      <= '0;
        end else begin
            if (csr_read_enable_i) begin
                rd_data_q <= rd_word;
            end
            rd_valid_q <= csr_read_enable_i;
            illegal_q  <= (csr_read_enable_i && !rd_map) || (csr_write_enable_i && !wr_map);
            inhibit_q  <= inhibit_d;
            pre_q      <= pre_d;
        end
    end

`ifdef PERF_OVERFLOW_IRQ_EN
    // A wrap in the same cycle as its W1C keeps the flag set.
    assign ovf_clr = (csr_write_enable_i && (csr_address_i == 12'h3A0)) ? csr_write_data_i : '0;
    assign ovf_d   = ((ovf_q & ~ovf_clr) | 32'(wrap_vec)) & CTR_MASK;

    // Sticky overflow flags and the interrupt that tracks them.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ovf_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            irq_q <= |ovf_d;
        end
    end

    assign overflow_irq_o = irq_q;
`endif

    assign csr_read_data_o  = rd_data_q;
    assign csr_read_valid_o = rd_valid_q;
    assign csr_illegal_o    = illegal_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed testbench for perf_counter_bank (NUM_EVENTS=2, TIME_DIV=4).
module tb_perf_counter_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_enable;
    logic        retire;
    logic [1:0]  event_in;
    logic [11:0] csr_address;
    logic        csr_read_enable;
    logic        csr_write_enable;
    logic [31:0] csr_write_data;
    logic [31:0] csr_read_data;
    logic        csr_read_valid;
    logic        csr_illegal;
`ifdef PERF_OVERFLOW_IRQ_EN
    logic        overflow_irq;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] rd;
    logic [31:0] t1, t2;

    always #5 clk = ~clk;

    perf_counter_bank #(
        .NUM_EVENTS    (2),
        .COUNTER_WIDTH (64),
        .TIME_DIV      (4)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .pipe_enable_i      (pipe_enable),
        .retire_i           (retire),
        .event_in_i         (event_in),
        .csr_address_i      (csr_address),
        .csr_read_enable_i  (csr_read_enable),
        .csr_write_enable_i (csr_write_enable),
        .csr_write_data_i   (csr_write_data),
`ifdef PERF_OVERFLOW_IRQ_EN
        .overflow_irq_o     (overflow_irq),
`endif
        .csr_read_data_o    (csr_read_data),
        .csr_read_valid_o   (csr_read_valid),
        .csr_illegal_o      (csr_illegal)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic csr_rd(input logic [11:0] a, output logic [31:0] d);
        csr_address     = a;
        csr_read_enable = 1'b1;
        step(1);
        csr_read_enable = 1'b0;
        d = csr_read_data;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_address      = a;
        csr_write_data   = d;
        csr_write_enable = 1'b1;
        step(1);
        csr_write_enable = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        pipe_enable      = 1'b1;
        retire           = 1'b0;
        event_in         = 2'b00;
        csr_address      = '0;
        csr_read_enable  = 1'b0;
        csr_write_enable = 1'b0;
        csr_write_data   = '0;
        step(3);
        chk("rst_rdata", 64'(csr_read_data), 64'h0);
        chk("rst_rvalid", 64'(csr_read_valid), 64'h0);
        chk("rst_illegal", 64'(csr_illegal), 64'h0);

        // 10 idle cycles after release, then read cycle and instret
        reset = 1'b0;
        step(10);
        csr_rd(12'hC00, rd);
        chk("cycle_10", 64'(rd), 64'd10);
        chk("rvalid_pulse", 64'(csr_read_valid), 64'h1);
        step(1);
        chk("rvalid_single", 64'(csr_read_valid), 64'h0);
        csr_rd(12'hC02, rd);
        chk("instret_0", 64'(rd), 64'h0);
        chk("illegal_ok_read", 64'(csr_illegal), 64'h0);

        // cycle writes, carry into the upper half, write-beats-increment
        csr_wr(12'h320, 32'h1);
        csr_wr(12'hB00, 32'hFFFF_FFFF);
        csr_wr(12'hB80, 32'h0);
        csr_rd(12'hC00, rd);
        chk("cycle_lo_preset", 64'(rd), 64'hFFFF_FFFF);
        csr_rd(12'hC80, rd);
        chk("cycle_hi_preset", 64'(rd), 64'h0);
        csr_wr(12'h320, 32'h0);
        csr_wr(12'h320, 32'h1);
        csr_rd(12'hC00, rd);
        chk("cycle_lo_carry", 64'(rd), 64'h0);
        csr_rd(12'hC80, rd);
        chk("cycle_hi_carry", 64'(rd), 64'h1);
        csr_wr(12'h320, 32'h0);
        csr_wr(12'hB80, 32'h7);
        csr_wr(12'h320, 32'h1);
        csr_rd(12'hC00, rd);
        chk("hi_write_drops_inc", 64'(rd), 64'h1);
        csr_rd(12'hC80, rd);
        chk("hi_write_value", 64'(rd), 64'h7);

        // read and write of the same CSR in one cycle: old value returned
        csr_address      = 12'hB00;
        csr_write_data   = 32'h1234;
        csr_read_enable  = 1'b1;
        csr_write_enable = 1'b1;
        step(1);
        csr_read_enable  = 1'b0;
        csr_write_enable = 1'b0;
        chk("rw_same_old", 64'(csr_read_data), 64'h1);
        chk("rw_same_valid", 64'(csr_read_valid), 64'h1);
        csr_rd(12'hC00, rd);
        chk("rw_same_new", 64'(rd), 64'h1234);
        csr_rd(12'hC80, rd);
        chk("lo_write_keeps_hi", 64'(rd), 64'h7);

        // mcountinhibit field mask, prescaled time, freeze of CY/IR
        csr_wr(12'h320, 32'hFFFF_FFFF);
        csr_rd(12'h320, rd);
        chk("inhibit_mask", 64'(rd), 64'h1D);
        csr_wr(12'h320, 32'h5);
        csr_rd(12'hC01, t1);
        csr_rd(12'hC00, rd);
        chk("cycle_frozen_a", 64'(rd), 64'h1234);
        csr_rd(12'hC02, rd);
        chk("instret_frozen_a", 64'(rd), 64'h0);
        step(13);
        csr_rd(12'hC01, t2);
        chk("time_16cyc", 64'(t2 - t1), 64'd4);
        csr_rd(12'hC00, rd);
        chk("cycle_frozen_b", 64'(rd), 64'h1234);

        // hpm counters, unmapped index, illegal writes
        event_in = 2'b11;
        step(5);
        event_in = 2'b00;
        csr_rd(12'hC03, rd);
        chk("hpm0_5", 64'(rd), 64'd5);
        csr_rd(12'hC04, rd);
        chk("hpm1_5", 64'(rd), 64'd5);
        csr_rd(12'hC05, rd);
        chk("unmapped_data", 64'(rd), 64'h0);
        chk("unmapped_valid", 64'(csr_read_valid), 64'h1);
        chk("unmapped_illegal", 64'(csr_illegal), 64'h1);
        csr_rd(12'hC83, rd);
        chk("hpm0_hi", 64'(rd), 64'h0);
        chk("hpm0_hi_legal", 64'(csr_illegal), 64'h0);
        csr_wr(12'hC00, 32'hDEAD);
        chk("ro_write_illegal", 64'(csr_illegal), 64'h1);
        csr_rd(12'hC00, rd);
        chk("ro_write_nochange", 64'(rd), 64'h1234);
        csr_wr(12'hB01, 32'h1);
        chk("time_write_illegal", 64'(csr_illegal), 64'h1);
        csr_wr(12'h320, 32'hD);
        event_in = 2'b11;
        step(3);
        event_in = 2'b00;
        csr_rd(12'hC03, rd);
        chk("hpm0_inhibited", 64'(rd), 64'd5);
        csr_rd(12'hC04, rd);
        chk("hpm1_8", 64'(rd), 64'd8);
        csr_wr(12'hB04, 32'hFFFF_FFFF);
        event_in = 2'b10;
        step(1);
        event_in = 2'b00;
        csr_rd(12'hC04, rd);
        chk("hpm1_lo_wrap", 64'(rd), 64'h0);
        csr_rd(12'hC84, rd);
        chk("hpm1_hi_carry", 64'(rd), 64'h1);

        // instret qualified by pipe_enable, then by IR inhibit
        csr_wr(12'h320, 32'h1);
        retire = 1'b1;
        pipe_enable = 1'b1; step(1);
        pipe_enable = 1'b0; step(1);
        pipe_enable = 1'b1; step(1);
        pipe_enable = 1'b0; step(1);
        retire = 1'b0;
        pipe_enable = 1'b1;
        csr_rd(12'hC02, rd);
        chk("instret_2", 64'(rd), 64'd2);
        csr_wr(12'h320, 32'h5);
        retire = 1'b1;
        step(2);
        retire = 1'b0;
        csr_rd(12'hC02, rd);
        chk("instret_ir_inh", 64'(rd), 64'd2);

        // base build: 3A0 is unmapped
`ifndef PERF_OVERFLOW_IRQ_EN
        csr_rd(12'h3A0, rd);
        chk("ovf_csr_unmapped", 64'(csr_illegal), 64'h1);
`endif

        // reset during an outstanding read
        csr_address     = 12'hC00;
        csr_read_enable = 1'b1;
        #2;
        reset = 1'b1;
        step(1);
        csr_read_enable = 1'b0;
        chk("rst_midread_valid", 64'(csr_read_valid), 64'h0);
        chk("rst_midread_data", 64'(csr_read_data), 64'h0);
        reset = 1'b0;
        step(1);
        chk("rst_midread_after", 64'(csr_read_valid), 64'h0);
        csr_rd(12'h320, rd);
        chk("rst_inhibit", 64'(rd), 64'h0);
        csr_rd(12'hC04, rd);
        chk("rst_hpm1", 64'(rd), 64'h0);
        csr_rd(12'hC84, rd);
        chk("rst_hpm1_hi", 64'(rd), 64'h0);

`ifdef PERF_OVERFLOW_IRQ_EN
        chk("irq_idle", 64'(overflow_irq), 64'h0);
        csr_wr(12'hB03, 32'hFFFF_FFFF);
        csr_wr(12'hB83, 32'hFFFF_FFFF);
        event_in = 2'b01;
        step(1);
        event_in = 2'b00;
        chk("irq_set", 64'(overflow_irq), 64'h1);
        csr_rd(12'hC03, rd);
        chk("hpm0_wrap_lo", 64'(rd), 64'h0);
        csr_rd(12'hC83, rd);
        chk("hpm0_wrap_hi", 64'(rd), 64'h0);
        csr_rd(12'h3A0, rd);
        chk("ovf_bit3", 64'(rd), 64'h8);
        csr_wr(12'h3A0, 32'h8);
        chk("irq_cleared", 64'(overflow_irq), 64'h0);
        csr_rd(12'h3A0, rd);
        chk("ovf_cleared", 64'(rd), 64'h0);
        csr_wr(12'hB03, 32'hFFFF_FFFF);
        csr_wr(12'hB83, 32'hFFFF_FFFF);
        event_in = 2'b01;
        csr_wr(12'h3A0, 32'h8);
        event_in = 2'b00;
        csr_rd(12'h3A0, rd);
        chk("wrap_beats_w1c", 64'(rd), 64'h8);
        chk("irq_wrap_w1c", 64'(overflow_irq), 64'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised successor to the core's fixed cycle/time/instret counters. Adds a bank of NUM_EVENTS hardware performance-monitor (hpm) counters, configurable counter width, and a time prescaler. Counters are machine-mode writable and can be individually inhibited through an mcountinhibit register. Sits beside the memory stage and serves CSR reads and writes with a registered 1-cycle read latency.

Parameters:
NUM_EVENTS, 4, number of hpm counters (hpmcounter3..3+NUM_EVENTS-1); legal range 0..29.
COUNTER_WIDTH, 64, width of every counter; legal range 33..64.
TIME_DIV, 1, the time counter increments once every TIME_DIV clk cycles; must be ≥1.

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
pipe_enable  in  1  pipeline advance qualifier
retire  in  1  writeback instruction_valid; counted only when pipe_enable=1
event_in  in  NUM_EVENTS  per-cycle event strobes; bit i drives hpmcounter(3+i)
csr_address  in  12  CSR address
csr_read_enable  in  1  read request
csr_write_enable  in  1  write request
csr_write_data  in  32  write data
csr_read_data  out  32  registered read data
csr_read_valid  out  1  pulses one cycle after an accepted read
csr_illegal  out  1  one-cycle pulse for an unmapped address or a write to a read-only address

Behaviour:
- Reset (async, active-high): all counters, the prescaler and mcountinhibit clear to 0; csr_read_data=0, csr_read_valid=0, csr_illegal=0. Reset asserted mid-read drops the pending csr_read_valid.
- Read-only map: C00 cycle, C01 time, C02 instret, C03+i hpmcounter; C80/C81/C82/C83+i return the corresponding upper halves.
- Writable map: B00 mcycle, B02 minstret, B03+i mhpmcounter (low halves); B80/B82/B83+i (high halves); 320 mcountinhibit.
- mcountinhibit field layout: bit0 CY, bit2 IR, bit(3+i) HPMi. All other bits read 0; writes to them are ignored.
- An hpm address with i ≥ NUM_EVENTS is unmapped.
- Upper-half read when COUNTER_WIDTH<64: bits [COUNTER_WIDTH-1:32] zero-extended. Upper-half write: bits above COUNTER_WIDTH are discarded.
- Increment rules, each per cycle:
  - cycle += 1 unless CY is set.
  - instret += 1 when retire and pipe_enable are both 1 and IR is clear.
  - hpm i += 1 when event_in[i]=1 and HPMi is clear.
  - The prescaler counts 0..TIME_DIV-1; time += 1 on terminal count. time ignores mcountinhibit and is not writable.
- Wrap-around: all-ones + 1 → 0, with no other side effect in the base build.
- Write: takes effect at the next clk edge. A write to a half modifies only that half.
- Write vs. increment in the same cycle: the write wins and the increment is lost. This applies even when the write targets the other half (the written value is taken, the other half is held).
- Read: csr_read_data and csr_read_valid register on the edge after csr_read_enable. The data is the pre-edge counter value.
- Read and write to the same CSR in the same cycle: the read returns the old value.
- Unmapped read: data=0, csr_read_valid=1, csr_illegal=1.
- Write to a C-range or unmapped address: no state change, csr_illegal=1.
- Simultaneous csr_read_enable and csr_write_enable: both are serviced.
- csr_illegal is the logical OR of the read and write error conditions in that cycle, registered (1-cycle latency).

Optional Feature:
PERF_OVERFLOW_IRQ_EN
- Defined:
  - Adds a sticky overflow bit per counter, set when that counter wraps.
  - Bit layout matches mcountinhibit (CY bit0, IR bit2, HPMi bit3+i); there is no bit for time.
  - The bits are readable at CSR 3A0 and cleared by write-1-to-clear at 3A0.
  - Adds output overflow_irq (1 bit) = OR of all sticky bits, registered.
  - A wrap and a W1C of the same bit in the same cycle leaves the bit set.
- Undefined: 3A0 is unmapped and overflow_irq is absent.

Test Plan:
- Reset release, 10 idle cycles (pipe_enable=1, retire=0), read C00 → data=10 (±the 1-cycle read latency per definition), C02 → 0, csr_read_valid exactly one cycle.
- Write B00=FFFFFFFF and B80=0 together with increments → read C00=FFFFFFFF then C80=0 after one inhibited cycle. With CY clear for 1 cycle → low=0, high=1.
- TIME_DIV=4, 16 cycles → time=4. Set mcountinhibit=0x5 → cycle and instret freeze while time keeps counting.
- NUM_EVENTS=2, event_in=2'b11 for 5 cycles → C03=5, C04=5. Read C05 → data 0 plus csr_illegal. Write C00 → csr_illegal, value unchanged.
- retire=1 with pipe_enable toggling 1,0,1,0 over 4 cycles → instret=2. Assert reset mid-read → csr_read_valid never asserts.
- PERF_OVERFLOW_IRQ_EN: hpm0 preset to all-ones, one event → counter=0, 3A0 bit3=1, overflow_irq=1. W1C 0x8 → irq deasserts next cycle.
